// File: rtl/unlock_pkg.sv
// Shared definitions for the unlock code transmitter and the 110 pattern detector.
package unlock_pkg;

  localparam int CODE_W_DEF  = 3;
  localparam int REPS_DEF    = 1;
  localparam int GAP_CYC_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FIN
  } state_e;

endpackage

// File: rtl/unlock_tx_shreg.sv
// Parallel-load, MSB-first shift register; zero-fills so it empties after a full frame.
module unlock_tx_shreg
  import unlock_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [CODE_W-1:0] din,
  output logic              msb
);

  logic [CODE_W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (clear) begin
      sh_d = '0;
    end else if (load) begin
      sh_d = din;
    end else if (shift) begin
      sh_d = {sh_q[CODE_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb = sh_q[CODE_W-1];

endmodule

// File: rtl/unlock_code_tx.sv
// Serial unlock code transmitter: sends the latched code REPS times, MSB first,
// with GAP_CYC idle cycles between frames and a one-cycle done pulse at the end.
module unlock_code_tx
  import unlock_pkg::*;
#(
  parameter int CODE_W  = CODE_W_DEF,
  parameter int REPS    = REPS_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CODE_W-1:0] code_in,
  input  logic              abort,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int              BW      = $clog2(CODE_W);
  localparam logic [BW-1:0]   BIT_TOP = BW'(CODE_W - 1);
  localparam logic [3:0]      REPS_L  = 4'(REPS);
  localparam logic [7:0]      GAP_TOP = 8'(GAP_CYC - 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]        rep_cnt_q, rep_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sh_load, sh_shift, sh_clear;
  logic [CODE_W-1:0] sh_din;
  logic [3:0]        rep_next;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    code_d      = code_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_clear    = 1'b0;
    sh_din      = code_q;
    rep_next    = rep_cnt_q + 4'd1;

    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      sh_clear    = 1'b1;
    end else begin
      case (state_q)
        // FIN accepts start too, so a held start runs frames back-to-back.
        IDLE, FIN: begin
          if (start) begin
            state_d     = SEND;
            code_d      = code_in;
            bit_cnt_d   = BIT_TOP;
            rep_cnt_d   = 4'd0;
            gap_cnt_d   = 8'd0;
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            sh_load     = 1'b1;
            sh_din      = code_in;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
          end
        end
        SEND: begin
          sh_shift = 1'b1;
          if (bit_cnt_q == '0) begin
            rep_cnt_d   = rep_next;
            out_valid_d = 1'b0;
            if (rep_next < REPS_L) begin
              state_d   = GAP;
              gap_cnt_d = GAP_TOP;
            end else begin
              state_d = FIN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == 8'd0) begin
            state_d     = SEND;
            bit_cnt_d   = BIT_TOP;
            out_valid_d = 1'b1;
            sh_load     = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rep_cnt_q   <= 4'd0;
      gap_cnt_q   <= 8'd0;
      code_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      code_q      <= code_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  unlock_tx_shreg #(
    .CODE_W(CODE_W)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (sh_load),
    .shift(sh_shift),
    .clear(sh_clear),
    .din  (sh_din),
    .msb  (out)
  );

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_unlock_code_tx.sv
// Bench for unlock_code_tx: directed scenarios plus random traffic against a
// schedule-based model that expands each accepted start into its full output trace.
module tb_unlock_code_tx;

  localparam int CODE_W  = 3;
  localparam int REPS    = 2;
  localparam int GAP_CYC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [CODE_W-1:0] code_in;
  logic              out, out_valid, busy, done;

  typedef struct packed {
    logic out;
    logic valid;
    logic busy;
    logic done;
  } exp_t;

  exp_t sched[$];
  int   n_vectors     = 0;
  int   n_miscompares = 0;
  int   done_seen     = 0;

  always #5 clk = ~clk;

  unlock_code_tx #(
    .CODE_W (CODE_W),
    .REPS   (REPS),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .code_in  (code_in),
    .abort    (abort),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t cur_exp();
    if (sched.size() == 0) return '0;
    return sched[0];
  endfunction

  // One accepted start expands into REPS frames, gaps between them, then FIN.
  task automatic push_tx(input logic [CODE_W-1:0] code);
    for (int r = 0; r < REPS; r++) begin
      for (int b = CODE_W - 1; b >= 0; b--)
        sched.push_back(exp_t'{out: code[b], valid: 1'b1, busy: 1'b1, done: 1'b0});
      if (r < REPS - 1)
        repeat (GAP_CYC) sched.push_back(exp_t'{out: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b0});
    end
    sched.push_back(exp_t'{out: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b1});
  endtask

  task automatic compareCycle();
    exp_t e;
    e = cur_exp();
    checkOutput("out", 32'(out), 32'(e.out));
    checkOutput("out_valid", 32'(out_valid), 32'(e.valid));
    checkOutput("busy", 32'(busy), 32'(e.busy));
    checkOutput("done", 32'(done), 32'(e.done));
    if (done === 1'b1) done_seen++;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [CODE_W-1:0] c);
    logic can_accept;
    start   = s;
    abort   = a;
    code_in = c;
    can_accept = (sched.size() == 0);
    if (!can_accept) can_accept = sched[0].done;
    if (a) sched.delete();
    else if (sched.size() != 0) void'(sched.pop_front());
    if (s && !a && can_accept) push_tx(c);
    @(posedge clk);
    #1;
    compareCycle();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, CODE_W'($urandom));
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    code_in = '0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_out", 32'(out), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] two-rep frame, code 110");
    applyStimulus(1'b1, 1'b0, 3'b110);
    idleCycles(10);

    $display("[TB] start during busy is ignored");
    done_seen = 0;
    applyStimulus(1'b1, 1'b0, 3'b110);
    applyStimulus(1'b0, 1'b0, 3'b110);
    applyStimulus(1'b1, 1'b0, 3'b001);
    idleCycles(10);
    checkOutput("done_count", 32'(done_seen), 32'd1);

    $display("[TB] abort mid-frame");
    done_seen = 0;
    applyStimulus(1'b1, 1'b0, 3'b101);
    applyStimulus(1'b0, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 3'b000);
    idleCycles(10);
    checkOutput("abort_done_count", 32'(done_seen), 32'd0);

    $display("[TB] start and abort together");
    applyStimulus(1'b1, 1'b1, 3'b111);
    idleCycles(3);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(1'b1, 1'b0, 3'b110);
    applyStimulus(1'b0, 1'b0, 3'b000);
    #2 rst = 1'b0;
    #1;
    sched.delete();
    checkOutput("arst_out", 32'(out), 32'd0);
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    compareCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b110);
    idleCycles(12);

    $display("[TB] start held high");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 3'b011);
    idleCycles(12);

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++)
      applyStimulus(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 4), CODE_W'($urandom));
    idleCycles(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/unlock_code_tx.md
UNLOCK_CODE_TX -- requirements
Module: unlock_code_tx

Interface
REQ-001 Parameter CODE_W, default 3: number of bits in the unlock code frame (legal range 2..16).
REQ-002 Parameter REPS, default 1: number of frame transmissions per start (legal range 1..15).
REQ-003 Parameter GAP_CYC, default 2: idle cycles between consecutive frames (legal range 1..255).
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  transmit request; sampled only in IDLE.
REQ-007 code_in  input  CODE_W  unlock code to send; latched when start is accepted.
REQ-008 abort  input  1  cancels any transmission in progress.
REQ-009 out  output  1  serial code bit, registered.
REQ-010 out_valid  output  1  high when out carries a code bit.
REQ-011 busy  output  1  high while a transmission is in progress.
REQ-012 done  output  1  one-cycle pulse when all REPS frames have completed.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SEND, GAP, FIN.
REQ-014 In IDLE with start=1 and abort=0, the FSM SHALL latch code_in, clear the bit and repetition counters, and go to SEND; busy SHALL rise in that same transition cycle.
REQ-015 In SEND, one bit SHALL be driven per cycle, MSB first, with out_valid=1; the first bit SHALL appear in the cycle after start is accepted (latency 1).
REQ-016 After bit 0 is driven, the FSM SHALL go to GAP if fewer than REPS frames have been sent, and otherwise to FIN.
REQ-017 GAP SHALL last exactly GAP_CYC cycles with out=0 and out_valid=0, then return to SEND with the bit counter reloaded to CODE_W-1.
REQ-018 FIN SHALL last one cycle with done=1 and busy=0, then go to IDLE.
REQ-019 Outside SEND, out and out_valid SHALL be 0.
REQ-020 start asserted while busy=1 SHALL be ignored; the latched code SHALL NOT change mid-transmission.
REQ-021 abort=1 in any state SHALL force IDLE on the next edge with out=0, out_valid=0 and busy=0, and done SHALL NOT pulse.
REQ-022 If start and abort are both 1 in IDLE, abort SHALL win and no transmission SHALL start.
REQ-023 start held high continuously SHALL begin a new transmission in the cycle after FIN (back-to-back), with no extra idle cycle.
REQ-024 The bit counter SHALL be $clog2(CODE_W) bits wide, the repetition counter 4 bits, and the gap counter 8 bits; no counter SHALL wrap past its terminal value.

Reset
REQ-025 rst=0 SHALL asynchronously force state=IDLE, out=0, out_valid=0, busy=0, done=0, and clear all counters and the code register.
REQ-026 Reset asserted mid-SEND SHALL drop out and out_valid to 0 without waiting for a clock edge.
REQ-027 After rst deassertion, the first start SHALL be accepted on the first rising edge at which rst=1.

Structure
REQ-028 The state enum (IDLE/SEND/GAP/FIN) and the default parameter values SHALL live in the shared package unlock_pkg, which the 110 pattern detector side also uses.
REQ-029 A single sub-module, unlock_tx_shreg, SHALL hold the parallel-load, MSB-first shift register; the FSM and counters SHALL stay in the top level.

Verification
REQ-030 Defaults, code_in=3'b110, start pulsed in cycle 0 -> out/out_valid = 1/1, 1/1, 0/1 in cycles 1-3; done=1 and busy=0 in cycle 4.
REQ-031 REPS=2, GAP_CYC=2, code 110 -> bits 1,1,0 in cycles 1-3; out_valid=0 in cycles 4-5; bits 1,1,0 in cycles 6-8; done in cycle 9.
REQ-032 start again in cycle 2 with code_in=3'b001 -> the serial stream is still 1,1,0, and exactly one done pulse occurs.
REQ-033 abort in cycle 2 -> busy=0 and out_valid=0 from cycle 3 onward, and no done pulse.
REQ-034 rst=0 asserted mid-cycle 2 -> out=0 and busy=0 immediately; after release, start in the next cycle -> normal 1,1,0 sequence.
REQ-035 start held high for 10 cycles, defaults -> frames in cycles 1-3 and 5-7, done pulses in cycles 4 and 8.
